// File: rtl/tetris_pkg.sv
// tetris_pkg: shared piece encoding and queue FSM states.
package tetris_pkg;
  localparam int PIECE_W = 3;
  localparam logic [PIECE_W-1:0] PIECE_NONE = 3'd7;
  typedef enum logic [PIECE_W-1:0] {I = 3'd0, O = 3'd1, T = 3'd2, S = 3'd3, Z = 3'd4, J = 3'd5, L = 3'd6} piece_e;
  typedef enum logic {FILL, RUN} queue_state_e;
endpackage

// File: rtl/piece_fifo.sv
// piece_fifo: DEPTH x PIECE_W synchronous FIFO exposing head and head+1.
module piece_fifo
  import tetris_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [PIECE_W-1:0] din,
  output logic [PIECE_W-1:0] head,
  output logic [PIECE_W-1:0] head_next,
  output logic [CNT_W-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [PIECE_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clock) begin
    if (reset) begin
      mem <= '{default: '0};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  assign head = mem[rd_ptr];
  assign head_next = mem[rd_ptr + 1'b1];
endmodule

// File: rtl/piece_queue.sv
// piece_queue: filters LFSR codes into a queue of tetromino IDs with FILL/RUN readiness.
// PIECE_NOREPEAT_EN additionally rejects a code equal to the last pushed piece.
module piece_queue
  import tetris_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PIECE_W-1:0] rnd,
  input  logic               req,
  output logic [PIECE_W-1:0] piece,
  output logic               piece_valid,
  output logic [PIECE_W-1:0] next_piece,
  output logic               next_valid,
  output logic               ready,
  output logic [CNT_W-1:0]   count
);
  queue_state_e state_q, state_d;
  logic pop, push, legal;
`ifdef PIECE_NOREPEAT_EN
  logic [PIECE_W-1:0] last_pushed;
  always_ff @(posedge clock) begin
    if (reset) last_pushed <= PIECE_NONE;
    else if (push) last_pushed <= rnd;
  end
  assign legal = rnd != PIECE_NONE && rnd != last_pushed;
`else
  assign legal = rnd != PIECE_NONE;
`endif
  assign piece_valid = count != '0;
  assign next_valid = count >= CNT_W'(2);
  assign pop = req && piece_valid;
  assign push = legal && (count < CNT_W'(DEPTH) || pop);
  assign ready = state_q == RUN;
  always_comb begin
    state_d = state_q;
    state_d = (state_q == FILL && count == CNT_W'(DEPTH)) ? RUN : state_q;
  end
  always_ff @(posedge clock) begin
    if (reset) state_q <= FILL;
    else state_q <= state_d;
  end
  piece_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(rnd),
    .head(piece),
    .head_next(next_piece),
    .count(count)
  );
endmodule

// File: tb/tb_piece_queue.sv
// tb_piece_queue: directed checks of filtering, pop/push interplay, FSM and reset.
module tb_piece_queue;
  logic clock = 0;
  logic reset = 1;
  logic [2:0] rnd = 3'd7;
  logic req = 0;
  logic [2:0] piece, next_piece;
  logic piece_valid, next_valid, ready;
  logic [2:0] count;
  int n_cmp = 0;
  int n_err = 0;

  piece_queue dut (
    .clock(clock),
    .reset(reset),
    .rnd(rnd),
    .req(req),
    .piece(piece),
    .piece_valid(piece_valid),
    .next_piece(next_piece),
    .next_valid(next_valid),
    .ready(ready),
    .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] r, input logic q);
    rnd = r;
    req = q;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    step(3'd7, 1'b0);
    reset = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_valid", piece_valid, 0);
    chk("rst_next_valid", next_valid, 0);
    chk("rst_ready", ready, 0);
    chk("rst_piece", piece, 0);
    chk("rst_next", next_piece, 0);

    step(3'd1, 0); chk("t1_count1", count, 1); chk("t1_piece1", piece, 1); chk("t1_valid1", piece_valid, 1);
    step(3'd2, 0); chk("t1_count2", count, 2); chk("t1_next2", next_piece, 2); chk("t1_nv2", next_valid, 1);
    step(3'd7, 0); chk("t1_reject7", count, 2);
    step(3'd3, 0); chk("t1_count3", count, 3);
    step(3'd4, 0); chk("t1_count4", count, 4); chk("t1_ready_late", ready, 0);
    step(3'd5, 0); chk("t1_full_hold", count, 4); chk("t1_ready", ready, 1);
    chk("t1_head", piece, 1); chk("t1_next", next_piece, 2);

    step(3'd7, 1); chk("t2_p2", piece, 2); chk("t2_c3", count, 3);
    step(3'd7, 1); chk("t2_p3", piece, 3); chk("t2_c2", count, 2); chk("t2_nv_c2", next_valid, 1);
    step(3'd7, 1); chk("t2_p4", piece, 4); chk("t2_c1", count, 1); chk("t2_nv_c1", next_valid, 0);
    chk("t2_ready", ready, 1);

    do_reset();
    step(3'd1, 0); step(3'd2, 0); step(3'd3, 0); step(3'd4, 0);
    chk("t3_full", count, 4);
    step(3'd6, 1); chk("t3_c_a", count, 4); chk("t3_p_a", piece, 2);
    step(3'd6, 1);
`ifdef PIECE_NOREPEAT_EN
    chk("t3_c_b", count, 3); chk("t3_p_b", piece, 3);
    step(3'd7, 1); chk("t4_p4", piece, 4); chk("t4_c2", count, 2);
    step(3'd7, 1); chk("t4_p6", piece, 6); chk("t4_c1", count, 1);
    step(3'd7, 1); chk("t4_c0", count, 0);
`else
    chk("t3_c_b", count, 4); chk("t3_p_b", piece, 3);
    step(3'd7, 1); chk("t4_p4", piece, 4); chk("t4_c3", count, 3);
    step(3'd7, 1); chk("t4_p6a", piece, 6); chk("t4_n6", next_piece, 6); chk("t4_c2", count, 2);
    step(3'd7, 1); chk("t4_p6b", piece, 6); chk("t4_c1", count, 1);
    step(3'd7, 1); chk("t4_c0", count, 0);
`endif
    for (int k = 0; k < 3; k++) begin
      step(3'd7, 1);
      chk("t4_underflow_count", count, 0);
      chk("t4_underflow_valid", piece_valid, 0);
    end
    step(3'd0, 1); chk("t4_push_empty_c", count, 1); chk("t4_push_empty_p", piece, 0);
    chk("t4_push_empty_v", piece_valid, 1); chk("t4_run_sticky", ready, 1);

    step(3'd1, 0); step(3'd2, 0);
    chk("t5_c3", count, 3);
    reset = 1;
    step(3'd5, 0);
    reset = 0;
    chk("t5_rst_c", count, 0); chk("t5_rst_v", piece_valid, 0); chk("t5_rst_ready", ready, 0);
    step(3'd3, 0); step(3'd4, 0); step(3'd5, 0); step(3'd6, 0);
    chk("t5_refill_c", count, 4); chk("t5_refill_p", piece, 3); chk("t5_refill_ready0", ready, 0);
    step(3'd7, 0); chk("t5_refill_ready1", ready, 1);

    do_reset();
    step(3'd5, 0); step(3'd5, 0); step(3'd5, 0); step(3'd2, 0); step(3'd2, 0); step(3'd5, 0);
    chk("t6_piece", piece, 5);
`ifdef PIECE_NOREPEAT_EN
    chk("t6_count", count, 3); chk("t6_next", next_piece, 2);
`else
    chk("t6_count", count, 4); chk("t6_next", next_piece, 5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/piece_queue.md
Name: piece_queue

Overview:
- Downstream consumer of the 3-bit `lfsr` output.
- Turns the raw pseudo-random stream into a validated queue of tetromino IDs 0..6, for the game-control FSM and the next-piece preview on the VGA display.
- Discards the illegal code 7 and buffers DEPTH pieces so a piece is always ready when the game requests a spawn.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- CNT_W, 3, width of the occupancy count; must hold the value DEPTH.

Ports:
- clock  input  1  system clock; all state updates on the posedge.
- reset  input  1  synchronous, active-high reset.
- rnd  input  3  LFSR output q; sampled every posedge.
- req  input  1  spawn request from the game FSM; one pop per cycle in which req and piece_valid are both high.
- piece  output  3  head-of-queue piece ID.
- piece_valid  output  1  head entry is valid (count != 0).
- next_piece  output  3  entry behind the head, for the preview.
- next_valid  output  1  high when count >= 2.
- ready  output  1  high in state RUN.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (clock-synchronous, active-high):
  - count=0; all storage entries=0; piece=0, next_piece=0.
  - piece_valid=0, next_valid=0, ready=0.
  - State=FILL; last_pushed=3'd7.
  - Reset asserted mid-operation discards all queued pieces on that edge.
- Accept rule (registered sample):
  - rnd is pushed at a posedge when rnd != 7 AND (count < DEPTH OR a pop occurs on the same edge).
  - rnd == 7 is never stored; it costs one cycle.
- Pop rule:
  - Occurs when req && piece_valid.
  - req while count==0 is ignored: no underflow, count stays 0.
  - req during FILL with count>0 still pops; ready is advisory only.
- Simultaneous push and pop:
  - count unchanged; head advances; the new entry is written at the tail.
  - Full + pop + legal rnd keeps count at DEPTH.
  - Empty + push + req: no pop, because piece_valid=0 that cycle; count becomes 1.
- Latency:
  - A legal rnd sampled at edge N into an empty queue gives piece=rnd and piece_valid=1 after edge N.
  - Outputs come directly from registered storage and pointers; no combinational path from rnd or req to the outputs.
- Pointers:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Full/empty are decided from count, not from pointer equality.
- State machine:
  - FILL -> RUN when count reaches DEPTH, evaluated on the registered count; ready rises one cycle after the queue first becomes full.
  - RUN stays in RUN whatever the occupancy; only reset returns the block to FILL.
- last_pushed:
  - Updated to the pushed value on every push.
  - Used only by the optional feature.

Optional Feature:
- Macro: PIECE_NOREPEAT_EN.
- Defined: an additional reject condition applies, rnd == last_pushed. This prevents identical consecutive queued pieces. After reset, last_pushed=7, so the first legal value is always accepted.
- Undefined: only rnd==7 is rejected; last_pushed logic may be optimised away; port list is identical in both builds.

Decomposition:
- Shared package tetris_pkg:
  - PIECE_W=3.
  - PIECE_NONE=3'd7.
  - Piece constants I=0, O=1, T=2, S=3, Z=4, J=5, L=6; these are also used by the rotation/collision logic and the VGA colour lookup.
- Sub-module piece_fifo:
  - Generic DEPTH x PIECE_W synchronous FIFO with push, pop, count, head and head+1 outputs.
  - piece_queue adds the accept filter, last_pushed register and FILL/RUN FSM around it.

Test Plan:
- Reset, then rnd=1,2,7,3,4,5 on consecutive cycles with req=0 -> queue holds 1,2,3,4; count=4; ready=1 on the cycle after count hits 4; 5 is not stored; piece=1, next_piece=2.
- Full queue, hold rnd=7, pulse req for 3 cycles -> piece goes 1->2->3->4, count 4->1, next_valid falls when count=1, ready stays 1.
- Full queue, req=1 with rnd=6 held for 2 cycles -> count stays 4, pieces 1 and 2 popped, tail becomes 6,6 (6 only once if PIECE_NOREPEAT_EN).
- Empty queue after pops, req=1 and rnd=7 for 3 cycles -> count stays 0, piece_valid=0; then rnd=0 -> piece=0 and piece_valid=1 one edge later.
- Reset asserted for 1 cycle mid-run with count=3 -> next cycle count=0, piece_valid=0, ready=0, state FILL; refill from rnd works normally.
- PIECE_NOREPEAT_EN defined, rnd=5,5,5,2,2,5 -> pushed 5,2,5; count=3. Undefined -> pushed 5,5,5,2 (full) and count=4.
